// File: rtl/tlut_pkg.sv
// Shared types and default widths for the temporal-LUT comparator sequencer.
package tlut_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } tlut_seq_state_e;

  localparam int TLUT_INPUT_WIDTH = 8;
  localparam int TLUT_DIM_A       = 16;
  localparam int TLUT_CMP_LAT     = 1;

endpackage

// File: rtl/tlut_seq_ctrl_if.sv
// Job-input and comparator-drive bundle between the operand source, sequencer and comparator array.
interface tlut_seq_ctrl_if
  import tlut_pkg::*;
#(
  parameter int INPUT_WIDTH = TLUT_INPUT_WIDTH,
  parameter int DIM_A       = TLUT_DIM_A
);

  logic                           in_valid;
  logic                           in_ready;
  logic [DIM_A*INPUT_WIDTH-1:0]   in_data;
  logic [INPUT_WIDTH-1:0]         cfg_len;
  logic                           abort;
  logic [DIM_A*INPUT_WIDTH-1:0]   cmp_in;
  logic [INPUT_WIDTH-1:0]         cmp_rng;
  logic                           cmp_en;
  logic                           out_valid;
  logic                           out_last;
  logic                           busy;

  modport slave (
    input  in_valid, in_data, cfg_len, abort,
    output in_ready, cmp_in, cmp_rng, cmp_en, out_valid, out_last, busy
  );

  modport master (
    output in_valid, in_data, cfg_len, abort,
    input  in_ready, cmp_in, cmp_rng, cmp_en, out_valid, out_last, busy
  );

endinterface

// File: rtl/tlut_dly_line.sv
// Fixed-depth shift register aligning sequencer flags with the comparator's register latency.
module tlut_dly_line #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stg_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_q <= '{default: '0};
    end else if (flush) begin
      stg_q <= '{default: '0};
    end else begin
      stg_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stg_q[i] <= stg_q[i-1];
      end
    end
  end

  assign dout = stg_q[DEPTH-1];

endmodule

// File: rtl/tlut_seq_ctrl.sv
// Sequencer for the temporal-LUT comparator array: latches a job's operands, sweeps the shared
// ramp for cfg_len+1 cycles and flags the comparator samples belonging to the job.
module tlut_seq_ctrl
  import tlut_pkg::*;
#(
  parameter int INPUT_WIDTH = TLUT_INPUT_WIDTH,
  parameter int DIM_A       = TLUT_DIM_A,
  parameter int CMP_LAT     = TLUT_CMP_LAT
) (
  input  logic            clk,
  input  logic            rst,
  tlut_seq_ctrl_if.slave  bus
);

  localparam int W   = INPUT_WIDTH;
  localparam int DCW = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(CMP_LAT - 1);

  tlut_seq_state_e       state_q;
  logic [W-1:0]          rng_q;
  logic [W-1:0]          len_q;
  logic [DIM_A*W-1:0]    op_q;
  logic [DCW-1:0]        drain_cnt_q;

  logic                  accept;
  logic                  at_end;
  logic                  vld_p0;
  logic                  last_p0;
  logic                  vld_p1;
  logic                  last_p1;

  assign accept = (state_q == S_IDLE) && bus.in_valid && !bus.abort;
  assign at_end = (rng_q == len_q);

  // Abort outranks both acceptance and sweep progress, from any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rng_q       <= '0;
      len_q       <= '0;
      op_q        <= '0;
      drain_cnt_q <= '0;
    end else if (bus.abort) begin
      state_q     <= S_IDLE;
      rng_q       <= '0;
      drain_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q    <= bus.in_data;
            len_q   <= bus.cfg_len;
            rng_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (at_end) begin
            state_q     <= S_DRAIN;
            drain_cnt_q <= '0;
          end else begin
            rng_q <= rng_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt_q == DRAIN_LAST) begin
            state_q <= S_IDLE;
          end else begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Stage p0: flags for the sample the comparator registers this cycle.
  assign vld_p0  = (state_q == S_RUN);
  assign last_p0 = (state_q == S_RUN) && at_end;

  tlut_dly_line #(
    .WIDTH (2),
    .DEPTH (CMP_LAT)
  ) u_dly (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.abort),
    .din   ({vld_p0, last_p0}),
    .dout  ({vld_p1, last_p1})
  );

  // Stage p1: flags aligned with the comparator output.
  assign bus.out_valid = vld_p1;
  assign bus.out_last  = last_p1;
  assign bus.cmp_en    = vld_p0;
  assign bus.cmp_rng   = rng_q;
  assign bus.cmp_in    = op_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.in_ready  = (state_q == S_IDLE) && !bus.abort;

endmodule
